// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Store sizes, store FSM states and the size-to-byte-mask mapping.
package lsu_pkg;

    typedef enum logic [1:0] {
        SB      = 2'b00,
        SH      = 2'b01,
        SW      = 2'b10,
        ILLEGAL = 2'b11
    } store_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BEAT0 = 2'b01,
        BEAT1 = 2'b10
    } store_state_e;

    localparam logic [3:0] MASK_SB = 4'b0001;
    localparam logic [3:0] MASK_SH = 4'b0011;
    localparam logic [3:0] MASK_SW = 4'b1111;

    function automatic logic [3:0] size_mask(input store_size_e size);
        case (size)
            SB:      size_mask = MASK_SB;
            SH:      size_mask = MASK_SH;
            SW:      size_mask = MASK_SW;
            default: size_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Places LSB-justified store data onto byte lanes across two adjacent words.
// Purely combinational; lanes without an enable are forced to zero.
module store_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  offset_i,
    input  store_size_e size_i,
    input  logic [31:0] data_i,
    output logic [63:0] lane_data_o,
    output logic [7:0]  lane_be_o
);

    logic [3:0]  mask;
    logic [63:0] shifted;

    always_comb begin
        mask        = size_mask(size_i);
        lane_be_o   = {4'b0000, mask} << offset_i;
        shifted     = {32'h0, data_i} << {offset_i, 3'b000};
        lane_data_o = '0;
        for (int i = 0; i < 8; i++) begin
            lane_data_o[8*i +: 8] = lane_be_o[i] ? shifted[8*i +: 8] : 8'h00;
        end
    end

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts one store at a time and issues one or two aligned memory
// write beats, holding each beat stable until the memory grants it.
module store_unit
    import lsu_pkg::*;
#(
    parameter bit          SPLIT_MISALIGNED = 1'b1,
    parameter int unsigned ADDR_W           = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid_i,
    output logic              st_ready_o,
    input  logic [ADDR_W-1:0] st_addr_i,
    input  logic [31:0]       st_data_i,
    input  logic [1:0]        st_size_i,
    output logic              st_done_o,
    output logic              st_err_o,
    output logic              dmem_req_o,
    input  logic              dmem_gnt_i,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [31:0]       dmem_wdata_o,
    output logic [3:0]        dmem_be_o
);

    store_state_e state_q;
    store_size_e  size;
    logic [31:0]  hi_data_q;
    logic [3:0]   hi_be_q;
    logic         need_hi_q;
    logic [63:0]  lane_data;
    logic [7:0]   lane_be;
    logic         accept;
    logic         need_hi;
    logic         reject;

    assign size    = store_size_e'(st_size_i);
    assign accept  = st_valid_i & st_ready_o;
    assign need_hi = |lane_be[7:4];
    assign reject  = (size == ILLEGAL) || (!SPLIT_MISALIGNED && need_hi);

    store_lane_align u_align (
        .offset_i    (st_addr_i[1:0]),
        .size_i      (size),
        .data_i      (st_data_i),
        .lane_data_o (lane_data),
        .lane_be_o   (lane_be)
    );

    // Ready is registered so it stays low while reset is held and rises on the first edge after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            st_ready_o   <= 1'b0;
            st_done_o    <= 1'b0;
            st_err_o     <= 1'b0;
            dmem_req_o   <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            dmem_be_o    <= '0;
            hi_data_q    <= '0;
            hi_be_q      <= '0;
            need_hi_q    <= 1'b0;
        end else begin
            st_done_o <= 1'b0;
            st_err_o  <= 1'b0;
            case (state_q)
                IDLE: begin
                    st_ready_o <= 1'b1;
                    if (accept) begin
                        if (reject) begin
                            st_err_o <= 1'b1;
                        end else begin
                            state_q      <= BEAT0;
                            st_ready_o   <= 1'b0;
                            dmem_req_o   <= 1'b1;
                            dmem_addr_o  <= {st_addr_i[ADDR_W-1:2], 2'b00};
                            dmem_wdata_o <= lane_data[31:0];
                            dmem_be_o    <= lane_be[3:0];
                            hi_data_q    <= lane_data[63:32];
                            hi_be_q      <= lane_be[7:4];
                            need_hi_q    <= need_hi;
                        end
                    end
                end
                BEAT0, BEAT1: begin
                    if (dmem_gnt_i) begin
                        if (state_q == BEAT0 && need_hi_q) begin
                            state_q      <= BEAT1;
                            dmem_addr_o  <= dmem_addr_o + ADDR_W'(4);
                            dmem_wdata_o <= hi_data_q;
                            dmem_be_o    <= hi_be_q;
                        end else begin
                            state_q      <= IDLE;
                            st_ready_o   <= 1'b1;
                            st_done_o    <= 1'b1;
                            dmem_req_o   <= 1'b0;
                            dmem_addr_o  <= '0;
                            dmem_wdata_o <= '0;
                            dmem_be_o    <= '0;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    dmem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed cases plus random stores checked
// against a byte-level reference model, on split and non-split instances.
module tb_store_unit;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        valid_s, valid_n, gnt;
    logic [31:0] addr, data;
    logic [1:0]  size;

    logic        rdy_s, done_s, err_s, req_s;
    logic [31:0] da_s, dw_s;
    logic [3:0]  be_s;
    logic        rdy_n, done_n, err_n, req_n;
    logic [31:0] da_n, dw_n;
    logic [3:0]  be_n;

    bit          sel_n;
    logic        rdy, done, err, req;
    logic [31:0] da, dw;
    logic [3:0]  be;

    int n_checks = 0;
    int n_fail   = 0;

    store_unit #(.SPLIT_MISALIGNED(1'b1), .ADDR_W(32)) u_dut_split (
        .clk          (clk),
        .rst_n        (rst_n),
        .st_valid_i   (valid_s),
        .st_ready_o   (rdy_s),
        .st_addr_i    (addr),
        .st_data_i    (data),
        .st_size_i    (size),
        .st_done_o    (done_s),
        .st_err_o     (err_s),
        .dmem_req_o   (req_s),
        .dmem_gnt_i   (gnt),
        .dmem_addr_o  (da_s),
        .dmem_wdata_o (dw_s),
        .dmem_be_o    (be_s)
    );

    store_unit #(.SPLIT_MISALIGNED(1'b0), .ADDR_W(32)) u_dut_nosplit (
        .clk          (clk),
        .rst_n        (rst_n),
        .st_valid_i   (valid_n),
        .st_ready_o   (rdy_n),
        .st_addr_i    (addr),
        .st_data_i    (data),
        .st_size_i    (size),
        .st_done_o    (done_n),
        .st_err_o     (err_n),
        .dmem_req_o   (req_n),
        .dmem_gnt_i   (gnt),
        .dmem_addr_o  (da_n),
        .dmem_wdata_o (dw_n),
        .dmem_be_o    (be_n)
    );

    always_comb begin
        if (sel_n) {rdy, done, err, req, da, dw, be} = {rdy_n, done_n, err_n, req_n, da_n, dw_n, be_n};
        else       {rdy, done, err, req, da, dw, be} = {rdy_s, done_s, err_s, req_s, da_s, dw_s, be_s};
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Byte-level reference: each data byte k lands at byte position offset+k of an 8-byte window.
    function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                                  input bit split, output bit e, output int nb,
                                  output logic [63:0] ba, output logic [63:0] bw,
                                  output logic [7:0] bbe);
        int off, nbytes;
        logic [7:0] lanes [8];
        bit         en    [8];
        off    = int'(a % 4);
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int i = 0; i < 8; i++) begin
            lanes[i] = 8'h00;
            en[i]    = 1'b0;
        end
        if (sz != 2'd3) begin
            for (int k = 0; k < nbytes; k++) begin
                lanes[off + k] = d[8*k +: 8];
                en[off + k]    = 1'b1;
            end
        end
        nb = (sz != 2'd3 && off + nbytes > 4) ? 2 : 1;
        e  = (sz == 2'd3) || (!split && nb == 2);
        for (int b = 0; b < 2; b++) begin
            ba[32*b +: 32] = (a - 32'(off)) + 32'(4 * b);
            for (int j = 0; j < 4; j++) begin
                bw[32*b + 8*j +: 8] = lanes[4*b + j];
                bbe[4*b + j]        = en[4*b + j];
            end
        end
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (rdy !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_before_accept", 64'(rdy), 64'd1);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                            input int dly, input bit ns);
        bit          e;
        int          nb;
        logic [63:0] ba, bw;
        logic [7:0]  bbe;
        model(a, d, sz, !ns, e, nb, ba, bw, bbe);
        sel_n = ns;
        wait_ready();
        addr = a;
        data = d;
        size = sz;
        if (ns) valid_n = 1'b1;
        else    valid_s = 1'b1;
        @(posedge clk); #1;
        valid_s = 1'b0;
        valid_n = 1'b0;
        // Scramble inputs to prove the unit latched them at accept.
        addr = $urandom;
        data = $urandom;
        size = 2'($urandom);
        if (e) begin
            @(negedge clk);
            check("err_pulse", 64'(err), 64'd1);
            check("err_no_req", 64'(req), 64'd0);
            check("err_no_done", 64'(done), 64'd0);
            check("err_ready", 64'(rdy), 64'd1);
            @(posedge clk); #1;
            @(negedge clk);
            check("err_clear", 64'(err), 64'd0);
            @(posedge clk); #1;
        end else begin
            for (int b = 0; b < nb; b++) begin
                for (int w = 0; w <= dly; w++) begin
                    gnt = (w == dly);
                    @(negedge clk);
                    check($sformatf("b%0d_req", b), 64'(req), 64'd1);
                    check($sformatf("b%0d_addr", b), 64'(da), 64'(ba[32*b +: 32]));
                    check($sformatf("b%0d_wdata", b), 64'(dw), 64'(bw[32*b +: 32]));
                    check($sformatf("b%0d_be", b), 64'(be), 64'(bbe[4*b +: 4]));
                    check($sformatf("b%0d_busy", b), {62'd0, rdy, done}, 64'd0);
                    @(posedge clk); #1;
                end
                gnt = 1'b0;
            end
            @(negedge clk);
            check("done_pulse", 64'(done), 64'd1);
            check("done_req_drop", 64'(req), 64'd0);
            check("done_ready", 64'(rdy), 64'd1);
            check("done_no_err", 64'(err), 64'd0);
            @(posedge clk); #1;
            @(negedge clk);
            check("done_clear", 64'(done), 64'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        valid_s = 1'b0;
        valid_n = 1'b0;
        gnt     = 1'b0;
        addr    = '0;
        data    = '0;
        size    = '0;
        sel_n   = 1'b0;

        #1;
        check("rst_outputs_s", {rdy_s, done_s, err_s, req_s, da_s, dw_s, be_s}, 64'd0);
        check("rst_outputs_n", {rdy_n, done_n, err_n, req_n, da_n, dw_n, be_n}, 64'd0);
        #11 rst_n = 1'b1;
        #1;
        check("rst_release_ready_low", 64'(rdy_s), 64'd0);
        @(posedge clk); #1;
        check("rst_release_ready_high", 64'(rdy_s), 64'd1);

        do_store(32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 0, 1'b0);
        do_store(32'h0000_0203, 32'h0000_00A5, 2'b00, 0, 1'b0);
        do_store(32'h0000_0003, 32'h0000_1234, 2'b01, 0, 1'b0);
        do_store(32'hFFFF_FFFE, 32'hAABB_CCDD, 2'b10, 3, 1'b0);
        do_store(32'h0000_0040, 32'h1111_2222, 2'b11, 0, 1'b0);
        do_store(32'h0000_0041, 32'h3333_4444, 2'b10, 0, 1'b1);
        do_store(32'h0000_0042, 32'h5555_6666, 2'b01, 1, 1'b1);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] ra;
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            do_store(ra, $urandom, 2'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                     bit'($urandom_range(0, 1)));
        end

        // Reset while BEAT0 waits for a grant.
        sel_n = 1'b0;
        wait_ready();
        addr    = 32'h0000_0100;
        data    = 32'h0123_4567;
        size    = 2'b10;
        gnt     = 1'b0;
        valid_s = 1'b1;
        @(posedge clk); #1;
        valid_s = 1'b0;
        @(negedge clk);
        check("inflight_req", 64'(req_s), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {rdy_s, done_s, err_s, req_s, da_s, dw_s, be_s}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_held_quiet", {rdy_s, done_s, err_s, req_s}, 64'd0);
        #2 rst_n = 1'b1;
        #1;
        check("rst2_ready_low", 64'(rdy_s), 64'd0);
        @(posedge clk); #1;
        check("rst2_ready_high", 64'(rdy_s), 64'd1);
        check("rst2_no_done", {done_s, req_s}, 64'd0);

        do_store(32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
